// File: rtl/tdc_line_encoder_if.sv
// Hit-side bus of the TDC line encoder: raw sample, coarse counters and
// control inputs, plus the encoded code, error and hit-count outputs.
interface tdc_line_encoder_if #(
    parameter int LINE_W = 63,
    parameter int CNT_W  = 3,
    parameter int FINE_W = 6,
    parameter int HCNT_W = 16
);
    logic                    inValid;
    logic [LINE_W-1:0]       rawData;
    logic [CNT_W-1:0]        counterA;
    logic [CNT_W-1:0]        counterB;
    logic [1:0]              level;
    logic [FINE_W-1:0]       offset;
    logic                    clrErr;
    logic                    outValid;
    logic [CNT_W+FINE_W-1:0] codeOut;
    logic                    hitErr;
    logic                    errFlagReg;
    logic [HCNT_W-1:0]       hitCnt;

    // Sample source side (drives the raw hit, reads the code back)
    modport master (
        output inValid, rawData, counterA, counterB, level, offset, clrErr,
        input  outValid, codeOut, hitErr, errFlagReg, hitCnt
    );

    // Encoder side
    modport slave (
        input  inValid, rawData, counterA, counterB, level, offset, clrErr,
        output outValid, codeOut, hitErr, errFlagReg, hitCnt
    );
endinterface

// File: rtl/tdc_line_encoder.sv
// Pipelined encoder for one TDC delay-line channel. A thermometer sample is
// turned into a bubble-tolerant fine code, a coarse counter phase is chosen
// away from the metastability window, and {coarse, fine} is presented three
// cycles after the sampling edge, one hit per cycle.
module tdc_line_encoder #(
    parameter int LINE_W = 63,
    parameter int CNT_W  = 3,
    parameter int FINE_W = 6,
    parameter int HCNT_W = 16
) (
    input  logic               clk40M,
    input  logic               reset,
    tdc_line_encoder_if.slave  bus
);
    localparam int              IDX_W = $clog2(LINE_W);
    localparam logic [FINE_W-1:0] HALF = FINE_W'((LINE_W + 1) / 2);
    localparam logic [FINE_W-1:0] FULL = FINE_W'(LINE_W);

    // S1: captured hit
    logic                    s1_valid_q, s1_valid_d;
    logic [LINE_W-1:0]       s1_raw_q, s1_raw_d;
    logic [CNT_W-1:0]        s1_ca_q, s1_ca_d, s1_cb_q, s1_cb_d;
    logic [1:0]              s1_lvl_q, s1_lvl_d;
    logic [FINE_W-1:0]       s1_off_q, s1_off_d;
    // S2: fine code
    logic                    s2_valid_q, s2_valid_d;
    logic [FINE_W-1:0]       s2_fine_q, s2_fine_d;
    logic [CNT_W-1:0]        s2_ca_q, s2_ca_d, s2_cb_q, s2_cb_d;
    logic [FINE_W-1:0]       s2_off_q, s2_off_d;
    // S3: coarse phase chosen
    logic                    s3_valid_q, s3_valid_d;
    logic [FINE_W-1:0]       s3_fine_q, s3_fine_d;
    logic [CNT_W-1:0]        s3_coarse_q, s3_coarse_d;
    logic [FINE_W-1:0]       win_dist;
    // Output stage
    logic                    out_valid_q, out_valid_d;
    logic [CNT_W+FINE_W-1:0] code_q, code_d;
    logic                    hit_err_q, hit_err_d;
    logic                    err_flag_q, err_flag_d;
    logic [HCNT_W-1:0]       hit_cnt_q, hit_cnt_d;

    // S1: capture the sample; a zero tolerance level behaves as one
    always_comb begin
        s1_valid_d = bus.inValid;
        s1_raw_d   = bus.rawData;
        s1_ca_d    = bus.counterA;
        s1_cb_d    = bus.counterB;
        s1_off_d   = bus.offset;
        if (bus.level == 2'd0) begin
            s1_lvl_d = 2'd1;
        end else begin
            s1_lvl_d = bus.level;
        end
    end

    // S2: fine = 1 + highest tap whose run of ones reaching down to it is at
    // least level long (or reaches tap 0), so short bubbles above the edge vanish
    always_comb begin
        logic             run_ok;
        logic [IDX_W-1:0] idx;
        s2_valid_d = s1_valid_q;
        s2_ca_d    = s1_ca_q;
        s2_cb_d    = s1_cb_q;
        s2_off_d   = s1_off_q;
        s2_fine_d  = '0;
        run_ok     = 1'b0;
        idx        = '0;
        for (int i = 0; i < LINE_W; i++) begin
            run_ok = 1'b1;
            for (int k = 0; k < 3; k++) begin
                idx = (i >= k) ? IDX_W'(i - k) : '0;
                if ((k < int'(s1_lvl_q)) && (i >= k)) begin
                    run_ok = run_ok & s1_raw_q[idx];
                end else begin
                    run_ok = run_ok;
                end
            end
            if (run_ok) begin
                s2_fine_d = FINE_W'(i + 1);
            end else begin
                s2_fine_d = s2_fine_d;
            end
        end
    end

    // S3: pick the counter phase that is stable for this fine position
    always_comb begin
        s3_valid_d = s2_valid_q;
        s3_fine_d  = s2_fine_q;
        win_dist   = s2_fine_q - s2_off_q;
        if (win_dist < HALF) begin
            s3_coarse_d = s2_ca_q;
        end else begin
            s3_coarse_d = s2_cb_q;
        end
    end

    // Output: assemble code, per-hit error, sticky flag (set beats clear), counter
    always_comb begin
        out_valid_d = s3_valid_q;
        if (s3_valid_q) begin
            code_d    = {s3_coarse_q, s3_fine_q};
            hit_err_d = (s3_fine_q == '0) || (s3_fine_q == FULL);
        end else begin
            code_d    = code_q;
            hit_err_d = hit_err_q;
        end
        if (out_valid_q && hit_err_q) begin
            err_flag_d = 1'b1;
        end else if (bus.clrErr) begin
            err_flag_d = 1'b0;
        end else begin
            err_flag_d = err_flag_q;
        end
        if (out_valid_q && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + HCNT_W'(1);
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // All pipeline and output state; reset drops every in-flight hit
    always_ff @(posedge clk40M) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_raw_q    <= '0;
            s1_ca_q     <= '0;
            s1_cb_q     <= '0;
            s1_lvl_q    <= 2'd1;
            s1_off_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_fine_q   <= '0;
            s2_ca_q     <= '0;
            s2_cb_q     <= '0;
            s2_off_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_fine_q   <= '0;
            s3_coarse_q <= '0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
            hit_err_q   <= 1'b0;
            err_flag_q  <= 1'b0;
            hit_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_raw_q    <= s1_raw_d;
            s1_ca_q     <= s1_ca_d;
            s1_cb_q     <= s1_cb_d;
            s1_lvl_q    <= s1_lvl_d;
            s1_off_q    <= s1_off_d;
            s2_valid_q  <= s2_valid_d;
            s2_fine_q   <= s2_fine_d;
            s2_ca_q     <= s2_ca_d;
            s2_cb_q     <= s2_cb_d;
            s2_off_q    <= s2_off_d;
            s3_valid_q  <= s3_valid_d;
            s3_fine_q   <= s3_fine_d;
            s3_coarse_q <= s3_coarse_d;
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            hit_err_q   <= hit_err_d;
            err_flag_q  <= err_flag_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign bus.outValid   = out_valid_q;
    assign bus.codeOut    = code_q;
    assign bus.hitErr     = hit_err_q;
    assign bus.errFlagReg = err_flag_q;
    assign bus.hitCnt     = hit_cnt_q;
endmodule

// File: tb/tb_tdc_line_encoder.sv
// Bench for tdc_line_encoder (63 taps): directed vector table, hand-written
// error-flag / streaming / reset sequences, and a randomized run scored
// against a behavioural model. A second instance with a 4-bit hit counter
// shares the stimulus to exercise saturation.
module tb_tdc_line_encoder;
    localparam int LW = 63;
    localparam int CW = 3;
    localparam int FW = 6;

    logic clk40M = 1'b0;
    logic reset;
    logic rst_sat;
    always #12 clk40M = ~clk40M;

    tdc_line_encoder_if #(.LINE_W(LW), .CNT_W(CW), .FINE_W(FW), .HCNT_W(16)) bi ();
    tdc_line_encoder_if #(.LINE_W(LW), .CNT_W(CW), .FINE_W(FW), .HCNT_W(4))  bs ();

    tdc_line_encoder #(.LINE_W(LW), .CNT_W(CW), .FINE_W(FW), .HCNT_W(16)) dut (
        .clk40M(clk40M), .reset(reset), .bus(bi));
    tdc_line_encoder #(.LINE_W(LW), .CNT_W(CW), .FINE_W(FW), .HCNT_W(4)) dut_sat (
        .clk40M(clk40M), .reset(rst_sat), .bus(bs));

    assign bs.inValid  = bi.inValid;
    assign bs.rawData  = bi.rawData;
    assign bs.counterA = bi.counterA;
    assign bs.counterB = bi.counterB;
    assign bs.level    = bi.level;
    assign bs.offset   = bi.offset;
    assign bs.clrErr   = bi.clrErr;

    typedef struct {
        logic [62:0] raw;
        logic [1:0]  lvl;
        logic [5:0]  off;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [8:0]  code;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [8:0] code;
        logic       err;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   hits_sent = 0;
    int   cyc = 0;
    int   nout = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    bit   sb_en = 1'b0;
    exp_t sbq[$];
    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [62:0] ones(input int n);
        logic [62:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Reference: scan taps from the top; accept the first tap whose run of
    // consecutive ones going downward is at least min(L, tap+1) long.
    function automatic int model_fine(input logic [62:0] raw, input int lvl);
        int l;
        int run;
        int j;
        l = (lvl == 0) ? 1 : lvl;
        for (int i = 62; i >= 0; i--) begin
            run = 0;
            j = i;
            while (j >= 0 && raw[j] == 1'b1) begin
                run++;
                j--;
            end
            if (run >= ((l < i + 1) ? l : i + 1)) return i + 1;
        end
        return 0;
    endfunction

    function automatic exp_t model(input logic [62:0] raw, input logic [1:0] lvl,
                                   input logic [5:0] off, input logic [2:0] a,
                                   input logic [2:0] b);
        exp_t e;
        int f;
        int d;
        int coarse;
        f = model_fine(raw, int'(lvl));
        d = (((f - int'(off)) % 64) + 64) % 64;
        coarse = (d < 32) ? int'(a) : int'(b);
        e.code = 9'(coarse * 64 + f);
        e.err  = (f == 0) || (f == 63);
        return e;
    endfunction

    task automatic drive(input logic [62:0] raw, input logic [1:0] lvl,
                         input logic [5:0] off, input logic [2:0] a, input logic [2:0] b);
        bi.inValid  = 1'b1;
        bi.rawData  = raw;
        bi.level    = lvl;
        bi.offset   = off;
        bi.counterA = a;
        bi.counterB = b;
        hits_sent++;
    endtask

    // Drive one random hit now and queue its modelled result
    task automatic send_random();
        logic [62:0] raw;
        logic [1:0]  lvl;
        logic [5:0]  off;
        logic [2:0]  a;
        logic [2:0]  b;
        int          idx;
        raw = ones($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                idx = $urandom_range(0, 62);
                raw[idx] = ~raw[idx];
            end
        end
        lvl = 2'($urandom_range(0, 3));
        off = 6'($urandom_range(0, 63));
        a   = 3'($urandom_range(0, 7));
        b   = 3'($urandom_range(0, 7));
        drive(raw, lvl, off, a, b);
        sbq.push_back(model(raw, lvl, off, a, b));
    endtask

    // One directed hit: silent for three cycles, valid for exactly one
    task automatic run_vec(input int id);
        vec_t v;
        v = vecs[id];
        @(negedge clk40M);
        drive(v.raw, v.lvl, v.off, v.a, v.b);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk40M);
            bi.inValid = 1'b0;
            if (j < 3) chk($sformatf("vec%0d_early_valid", id), 32'(bi.outValid), 32'd0);
        end
        chk($sformatf("vec%0d_valid", id), 32'(bi.outValid), 32'd1);
        chk($sformatf("vec%0d_code", id), 32'(bi.codeOut), 32'(v.code));
        chk($sformatf("vec%0d_err", id), 32'(bi.hitErr), 32'(v.err));
        @(negedge clk40M);
        chk($sformatf("vec%0d_one_cycle", id), 32'(bi.outValid), 32'd0);
    endtask

    // Send one hit and stop at the negedge where its outValid is visible
    task automatic hit_to_output(input logic [62:0] raw);
        @(negedge clk40M);
        drive(raw, 2'd3, 6'd0, 3'd5, 3'd2);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk40M);
            bi.inValid = 1'b0;
        end
    endtask

    always @(posedge clk40M) cyc <= cyc + 1;

    // Scoreboard: every outValid must match the oldest queued expectation
    always @(negedge clk40M) begin
        exp_t e;
        if (sb_en && bi.outValid === 1'b1) begin
            nout++;
            if (nout == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (sbq.size() == 0) begin
                chk("sb_unexpected_out", 32'(bi.codeOut), 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk("sb_code", 32'(bi.codeOut), 32'(e.code));
                chk("sb_err", 32'(bi.hitErr), 32'(e.err));
            end
        end
    end

    initial begin
        logic [62:0] bub;
        int          highs;
        int          rand_hits;
        reset = 1'b1;
        rst_sat = 1'b1;
        bi.inValid = 1'b0;
        bi.rawData = '0;
        bi.counterA = '0;
        bi.counterB = '0;
        bi.level = 2'd0;
        bi.offset = '0;
        bi.clrErr = 1'b0;

        repeat (3) @(negedge clk40M);
        chk("rst_outValid", 32'(bi.outValid), 32'd0);
        chk("rst_codeOut", 32'(bi.codeOut), 32'd0);
        chk("rst_hitErr", 32'(bi.hitErr), 32'd0);
        chk("rst_errFlag", 32'(bi.errFlagReg), 32'd0);
        chk("rst_hitCnt", 32'(bi.hitCnt), 32'd0);
        chk("rst_sat_hitCnt", 32'(bs.hitCnt), 32'd0);
        reset = 1'b0;
        rst_sat = 1'b0;

        bub = ones(20) | (63'd3 << 21);
        vecs[0]  = '{ones(20), 2'd3, 6'd0,  3'd5, 3'd2, 9'd340, 1'b0};
        vecs[1]  = '{bub,      2'd3, 6'd0,  3'd5, 3'd2, 9'd340, 1'b0};
        vecs[2]  = '{bub,      2'd2, 6'd0,  3'd5, 3'd2, 9'd343, 1'b0};
        vecs[3]  = '{bub,      2'd0, 6'd0,  3'd5, 3'd2, 9'd343, 1'b0};
        vecs[4]  = '{bub,      2'd1, 6'd0,  3'd5, 3'd2, 9'd343, 1'b0};
        vecs[5]  = '{ones(40), 2'd3, 6'd0,  3'd5, 3'd2, 9'd168, 1'b0};
        vecs[6]  = '{ones(40), 2'd3, 6'd20, 3'd5, 3'd2, 9'd360, 1'b0};
        vecs[7]  = '{ones(10), 2'd3, 6'd20, 3'd5, 3'd2, 9'd138, 1'b0};
        vecs[8]  = '{ones(32), 2'd3, 6'd0,  3'd5, 3'd2, 9'd160, 1'b0};
        vecs[9]  = '{ones(31), 2'd3, 6'd0,  3'd5, 3'd2, 9'd351, 1'b0};
        vecs[10] = '{ones(1),  2'd3, 6'd0,  3'd5, 3'd2, 9'd321, 1'b0};
        vecs[11] = '{63'd0,    2'd3, 6'd0,  3'd5, 3'd2, 9'd320, 1'b1};
        vecs[12] = '{ones(63), 2'd3, 6'd0,  3'd5, 3'd2, 9'd191, 1'b1};
        for (int i = 0; i < 13; i++) run_vec(i);
        chk("table_hitCnt", 32'(bi.hitCnt), 32'd13);
        chk("table_sat_hitCnt", 32'(bs.hitCnt), 32'd13);

        // Sticky flag: set by the table's error hits, cleared by clrErr alone
        @(negedge clk40M);
        chk("flag_after_table", 32'(bi.errFlagReg), 32'd1);
        bi.clrErr = 1'b1;
        @(negedge clk40M);
        bi.clrErr = 1'b0;
        chk("flag_clr_alone", 32'(bi.errFlagReg), 32'd0);

        // Empty line: flag rises the cycle after the erroneous outValid
        hit_to_output(63'd0);
        chk("empty_valid", 32'(bi.outValid), 32'd1);
        chk("empty_fine", 32'(bi.codeOut[5:0]), 32'd0);
        chk("empty_err", 32'(bi.hitErr), 32'd1);
        chk("empty_flag_not_yet", 32'(bi.errFlagReg), 32'd0);
        @(negedge clk40M);
        chk("empty_flag_set", 32'(bi.errFlagReg), 32'd1);
        bi.clrErr = 1'b1;
        @(negedge clk40M);
        bi.clrErr = 1'b0;
        chk("flag_clr_again", 32'(bi.errFlagReg), 32'd0);

        // Overflowed line with clrErr on the same cycle: set wins
        hit_to_output(ones(63));
        chk("full_valid", 32'(bi.outValid), 32'd1);
        chk("full_err", 32'(bi.hitErr), 32'd1);
        bi.clrErr = 1'b1;
        @(negedge clk40M);
        bi.clrErr = 1'b0;
        chk("flag_set_wins", 32'(bi.errFlagReg), 32'd1);
        chk("hold_code", 32'(bi.codeOut), 32'd191);
        chk("hold_err", 32'(bi.hitErr), 32'd1);

        // Streaming: 10 back-to-back hits from a fresh reset
        reset = 1'b1;
        @(negedge clk40M);
        reset = 1'b0;
        chk("rst2_hitCnt", 32'(bi.hitCnt), 32'd0);
        chk("rst2_errFlag", 32'(bi.errFlagReg), 32'd0);
        sbq.delete();
        nout = 0;
        sb_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_random();
            @(negedge clk40M);
        end
        bi.inValid = 1'b0;
        repeat (6) @(negedge clk40M);
        chk("stream_count", 32'(nout), 32'd10);
        chk("stream_contiguous", 32'(last_cyc - first_cyc + 1), 32'd10);
        chk("stream_drained", 32'(sbq.size()), 32'd0);
        chk("stream_hitCnt", 32'(bi.hitCnt), 32'd10);
        sb_en = 1'b0;

        // Reset with two hits in flight: neither may come out
        @(negedge clk40M);
        drive(ones(5), 2'd1, 6'd0, 3'd1, 3'd1);
        @(negedge clk40M);
        drive(ones(6), 2'd1, 6'd0, 3'd1, 3'd1);
        @(negedge clk40M);
        bi.inValid = 1'b0;
        reset = 1'b1;
        @(negedge clk40M);
        reset = 1'b0;
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk40M);
            if (bi.outValid === 1'b1) highs++;
        end
        chk("inflight_no_valid", 32'(highs), 32'd0);
        chk("inflight_hitCnt", 32'(bi.hitCnt), 32'd0);

        // Randomized traffic against the model
        sbq.delete();
        nout = 0;
        rand_hits = 0;
        sb_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                send_random();
                rand_hits++;
            end else begin
                bi.inValid = 1'b0;
            end
            bi.clrErr = ($urandom_range(0, 7) == 0);
            @(negedge clk40M);
        end
        bi.inValid = 1'b0;
        bi.clrErr = 1'b0;
        repeat (8) @(negedge clk40M);
        sb_en = 1'b0;
        chk("rand_drained", 32'(sbq.size()), 32'd0);
        chk("rand_count", 32'(nout), 32'(rand_hits));
        chk("rand_hitCnt", 32'(bi.hitCnt), 32'(rand_hits));
        chk("sat_hitCnt", 32'(bs.hitCnt), 32'((hits_sent < 15) ? hits_sent : 15));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
